// File: rtl/fft_unload.sv
// Streams the N FFT result words out of the sample RAM in natural frequency order.
// A 2-deep skid FIFO absorbs the one-cycle RAM read latency so downstream backpressure never loses a word.
module fft_unload #(
    parameter int N_POINTS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int BIT_REVERSE = 1
) (
    input  logic              i_clk,
    input  logic              i_n_rst,
    input  logic              i_unload_start,
    input  logic              i_unload_abort,
    output logic              o_ram_rd_en,
    output logic [ADDR_W-1:0] o_ram_rd_addr,
    input  logic [DATA_W-1:0] i_ram_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [ADDR_W-1:0] o_out_index,
    output logic              o_out_last,
    output logic              o_unload_busy,
    output logic              o_unload_done
);

    // state | meaning
    // IDLE  | waiting for unload_start
    // RUN   | issuing reads and streaming samples
    // DONE  | last sample accepted, unload_done pulses for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W:0]   RD_LIMIT = (ADDR_W+1)'(N_POINTS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS-1);

    function automatic logic [ADDR_W-1:0] f_bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
        return r;
    endfunction

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_rd_cnt;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_cap_idx;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_idx  [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_idx;
    logic [ADDR_W-1:0] w_head_idx;
    logic [1:0]        w_count_nxt;

    assign w_valid    = (r_count != 2'd0);
    assign w_pop      = w_valid & i_out_ready & ~i_unload_abort;
    assign w_push     = r_inflight & ~i_unload_abort;
    assign w_head_idx = r_fifo_idx[r_rd_ptr];
    assign w_rd_idx   = r_rd_cnt[ADDR_W-1:0];

    // Occupancy counts words already requested so the FIFO can never overflow.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = (r_state == S_RUN) && !i_unload_abort
                     && (r_rd_cnt < RD_LIMIT) && (w_occ < 3'd2);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + 2'd1;
        else if (!w_push && w_pop)
            w_count_nxt = r_count - 2'd1;
    end

    assign o_ram_rd_en   = w_rd_en;
    assign o_ram_rd_addr = !w_rd_en ? '0 :
                           (BIT_REVERSE != 0) ? f_bitrev(w_rd_idx) : w_rd_idx;
    assign o_out_valid   = w_valid;
    assign o_out_data    = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign o_out_index   = w_valid ? w_head_idx : '0;
    assign o_out_last    = w_valid && (w_head_idx == LAST_IDX);
    assign o_unload_busy = (r_state != S_IDLE);
    assign o_unload_done = (r_state == S_DONE);

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state    <= S_IDLE;
            r_rd_cnt   <= '0;
            r_inflight <= 1'b0;
            r_cap_idx  <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (i_unload_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: if (i_unload_start) r_state <= S_RUN;
                    S_RUN:  if (w_pop && (w_head_idx == LAST_IDX)) r_state <= S_DONE;
                    S_DONE: r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
            if (r_state != S_RUN || i_unload_abort) begin
                r_rd_cnt  <= '0;
                r_cap_idx <= '0;
            end else begin
                if (w_rd_en) r_rd_cnt  <= r_rd_cnt + (ADDR_W+1)'(1);
                if (w_push)  r_cap_idx <= r_cap_idx + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_idx[0]  <= '0;
            r_fifo_idx[1]  <= '0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else if (i_unload_abort) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= i_ram_rd_data;
                r_fifo_idx[r_wr_ptr]  <= r_cap_idx;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// Bench for fft_unload: a scoreboard checks every accepted sample, a cycle table
// checks the start-to-done timing, and hand sequences cover stall, abort, reset and re-start.
module tb_fft_unload;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NP = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst, start_a, start_b, abort, ready, sel;

    logic          a_en, a_valid, a_last, a_busy, a_done;
    logic [AW-1:0] a_addr, a_idx;
    logic [DW-1:0] a_data, a_rdata = 32'hDEAD_BEEF;
    logic          b_en, b_valid, b_last, b_busy, b_done;
    logic [AW-1:0] b_addr, b_idx;
    logic [DW-1:0] b_data, b_rdata = 32'hDEAD_BEEF;

    fft_unload #(.N_POINTS(NP), .ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(1)) dut_a (
        .i_clk(clk), .i_n_rst(n_rst), .i_unload_start(start_a), .i_unload_abort(abort),
        .o_ram_rd_en(a_en), .o_ram_rd_addr(a_addr), .i_ram_rd_data(a_rdata),
        .o_out_valid(a_valid), .i_out_ready(ready), .o_out_data(a_data),
        .o_out_index(a_idx), .o_out_last(a_last), .o_unload_busy(a_busy), .o_unload_done(a_done));

    fft_unload #(.N_POINTS(NP), .ADDR_W(AW), .DATA_W(DW), .BIT_REVERSE(0)) dut_b (
        .i_clk(clk), .i_n_rst(n_rst), .i_unload_start(start_b), .i_unload_abort(abort),
        .o_ram_rd_en(b_en), .o_ram_rd_addr(b_addr), .i_ram_rd_data(b_rdata),
        .o_out_valid(b_valid), .i_out_ready(ready), .o_out_data(b_data),
        .o_out_index(b_idx), .o_out_last(b_last), .o_unload_busy(b_busy), .o_unload_done(b_done));

    // RAM preloaded with word = address; garbage whenever no read was issued
    always @(posedge clk) a_rdata <= a_en ? DW'(a_addr) : 32'hDEAD_BEEF;
    always @(posedge clk) b_rdata <= b_en ? DW'(b_addr) : 32'hDEAD_BEEF;

    logic          m_en, m_valid, m_last, m_busy, m_done;
    logic [AW-1:0] m_addr, m_idx;
    logic [DW-1:0] m_data;
    always_comb begin
        m_en = a_en; m_valid = a_valid; m_last = a_last; m_busy = a_busy; m_done = a_done;
        m_addr = a_addr; m_idx = a_idx; m_data = a_data;
        if (sel) begin
            m_en = b_en; m_valid = b_valid; m_last = b_last; m_busy = b_busy; m_done = b_done;
            m_addr = b_addr; m_idx = b_idx; m_data = b_data;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int bitrev5(input int v);
        logic [4:0] a, r;
        a = v[4:0];
        for (int i = 0; i < 5; i++) r[i] = a[4-i];
        return int'(r);
    endfunction

    typedef struct {
        logic [31:0] data;
        int          idx;
        bit          last;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int cyc; bit en; int rd_i; bit valid; int idx; bit last; bit done; bit busy;
    } vec_t;
    vec_t tbl[10];

    int edge_cnt = 0;
    int base = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    bit          log_en = 0;
    int          lg_en[64], lg_addr[64], lg_valid[64], lg_idx[64];
    int          lg_last[64], lg_done[64], lg_busy[64];
    logic [31:0] lg_data[64];
    int          acc = 0, rd_seen = 0, done_seen = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        int c;
        exp_t e;
        if (!n_rst) begin
            prev_hold = 0;
        end else begin
            c = edge_cnt - base;
            if (log_en && c >= 0 && c < 64) begin
                lg_en[c] = int'(m_en); lg_addr[c] = int'(m_addr); lg_valid[c] = int'(m_valid);
                lg_idx[c] = int'(m_idx); lg_last[c] = int'(m_last); lg_done[c] = int'(m_done);
                lg_busy[c] = int'(m_busy); lg_data[c] = m_data;
            end
            if (m_en) rd_seen++;
            if (m_done) done_seen++;
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && ready && !abort) begin
                if (sb.size() == 0) begin
                    check("sb_extra_sample_idx", m_idx, -1);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", m_data, e.data);
                    check("sb_index", m_idx, e.idx);
                    check("sb_last", m_last, e.last);
                end
                acc++;
            end
            prev_hold = m_valid && !ready && !abort;
            prev_data = m_data;
        end
    end

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input bit s, input bit br);
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            e.data = br ? 32'(bitrev5(i)) : 32'(i);
            e.idx  = i;
            e.last = (i == NP - 1);
            sb.push_back(e);
        end
        sel = s;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        base = edge_cnt;
        wait_edge();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (!m_busy) break;
            wait_edge();
        end
        if (k == budget) check("timeout_busy", m_busy, 0);
    endtask

    task automatic check_table(input bit br);
        int c, ea, ed;
        for (int i = 0; i < 10; i++) begin
            c  = tbl[i].cyc;
            ea = tbl[i].en ? (br ? bitrev5(tbl[i].rd_i) : tbl[i].rd_i) : 0;
            ed = tbl[i].valid ? (br ? bitrev5(tbl[i].idx) : tbl[i].idx) : 0;
            check($sformatf("c%0d_rd_en_br%0d", c, br), lg_en[c], tbl[i].en);
            check($sformatf("c%0d_rd_addr_br%0d", c, br), lg_addr[c], ea);
            check($sformatf("c%0d_valid_br%0d", c, br), lg_valid[c], tbl[i].valid);
            check($sformatf("c%0d_index_br%0d", c, br), lg_idx[c], tbl[i].idx);
            check($sformatf("c%0d_data_br%0d", c, br), lg_data[c], ed);
            check($sformatf("c%0d_last_br%0d", c, br), lg_last[c], tbl[i].last);
            check($sformatf("c%0d_done_br%0d", c, br), lg_done[c], tbl[i].done);
            check($sformatf("c%0d_busy_br%0d", c, br), lg_busy[c], tbl[i].busy);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, a_en, 0);
        check({tag, "_rd_addr"}, a_addr, 0);
        check({tag, "_valid"}, a_valid, 0);
        check({tag, "_data"}, a_data, 0);
        check({tag, "_index"}, a_idx, 0);
        check({tag, "_last"}, a_last, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_done"}, a_done, 0);
    endtask

    int done0;

    initial begin
        //          cyc en rd_i valid idx last done busy
        tbl[0] = '{ 0, 0,  0,  0,  0, 0, 0, 0};
        tbl[1] = '{ 1, 1,  0,  0,  0, 0, 0, 1};
        tbl[2] = '{ 2, 1,  1,  0,  0, 0, 0, 1};
        tbl[3] = '{ 3, 1,  2,  1,  0, 0, 0, 1};
        tbl[4] = '{ 4, 1,  3,  1,  1, 0, 0, 1};
        tbl[5] = '{32, 1, 31,  1, 29, 0, 0, 1};
        tbl[6] = '{33, 0,  0,  1, 30, 0, 0, 1};
        tbl[7] = '{34, 0,  0,  1, 31, 1, 0, 1};
        tbl[8] = '{35, 0,  0,  0,  0, 0, 1, 1};
        tbl[9] = '{36, 0,  0,  0,  0, 0, 0, 0};

        n_rst = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; ready = 1'b1; sel = 1'b0;
        #3;
        check_zero_outputs("reset");
        wait_edge(); wait_edge();
        n_rst = 1'b1;
        wait_edge(); wait_edge();

        // natural-order stream, bit-reversed addressing
        acc = 0; done_seen = 0; log_en = 1;
        start_run(0, 1);
        wait_idle(100);
        wait_edge();
        log_en = 0;
        check_table(1);
        check("br1_accepted", acc, NP);
        check("br1_done_pulses", done_seen, 1);
        check("br1_sb_left", sb.size(), 0);

        // linear addressing, same timing
        acc = 0; done_seen = 0; log_en = 1;
        start_run(1, 0);
        wait_idle(100);
        wait_edge();
        log_en = 0;
        check_table(0);
        check("br0_accepted", acc, NP);
        check("br0_done_pulses", done_seen, 1);
        check("br0_sb_left", sb.size(), 0);

        // backpressure: stall 10 cycles, then random ready
        acc = 0; done_seen = 0; rd_seen = 0; ready = 1'b0;
        start_run(0, 1);
        repeat (10) wait_edge();
        check("stall_reads", rd_seen, 2);
        check("stall_valid", m_valid, 1);
        for (int k = 0; k < 600 && m_busy; k++) begin
            ready = 1'($urandom_range(0, 1));
            wait_edge();
        end
        ready = 1'b1;
        wait_idle(50);
        check("stall_accepted", acc, NP);
        check("stall_done_pulses", done_seen, 1);
        check("stall_sb_left", sb.size(), 0);

        // abort after 12 accepts
        acc = 0; done0 = done_seen;
        start_run(0, 1);
        for (int k = 0; k < 100 && acc < 12; k++) wait_edge();
        check("abort_reached_12", acc, 12);
        abort = 1'b1;
        wait_edge();
        abort = 1'b0;
        check("abort_busy", m_busy, 0);
        check("abort_valid", m_valid, 0);
        repeat (3) wait_edge();
        check("abort_no_done", done_seen, done0);
        check("abort_accepted", acc, 12);
        sb.delete();
        acc = 0;
        start_run(0, 1);
        wait_idle(100);
        check("after_abort_accepted", acc, NP);
        check("after_abort_done", done_seen - done0, 1);
        check("after_abort_sb_left", sb.size(), 0);

        // asynchronous reset mid-transfer
        done0 = done_seen;
        start_run(0, 1);
        repeat (8) wait_edge();
        #2 n_rst = 1'b0;
        #1 check_zero_outputs("async_rst");
        @(posedge clk);
        #3 n_rst = 1'b1;
        sb.delete();
        repeat (5) wait_edge();
        check("post_rst_busy", m_busy, 0);
        check("post_rst_valid", m_valid, 0);
        check("post_rst_rd_en", m_en, 0);
        check("post_rst_no_done", done_seen, done0);

        // second start during a transfer is ignored
        acc = 0; done0 = done_seen;
        start_run(0, 1);
        repeat (4) wait_edge();
        start_a = 1'b1;
        wait_edge();
        start_a = 1'b0;
        wait_idle(100);
        repeat (10) wait_edge();
        check("restart_accepted", acc, NP);
        check("restart_done", done_seen - done0, 1);
        check("restart_sb_left", sb.size(), 0);
        check("restart_idle_busy", m_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
